// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// lane geometry, wait-counter width, default sizing and the byte-lane merge helper.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_BUSY = 2'd1,
        DM_RESP = 2'd2
    } dm_state_t;

    localparam int unsigned DM_DATA_W        = 32;
    localparam int unsigned DM_LANES         = 4;
    localparam int unsigned DM_LANE_W        = 8;
    localparam int unsigned DM_CNT_W         = 4;
    localparam int unsigned DM_DEFAULT_DEPTH = 1024;
    localparam int unsigned DM_DEFAULT_WAIT  = 1;

    // Replace each enabled byte lane of old_word with the matching lane of wdata.
    function automatic logic [DM_DATA_W-1:0] dm_merge(
        input logic [DM_DATA_W-1:0] old_word,
        input logic [DM_DATA_W-1:0] wdata,
        input logic [DM_LANES-1:0]  be
    );
        logic [DM_DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < DM_LANES; i++) begin
            if (be[i]) begin
                merged[DM_LANE_W*i +: DM_LANE_W] = wdata[DM_LANE_W*i +: DM_LANE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_wait_counter.sv
// Down-counter that paces the BUSY phase of the responder: load, decrement, zero flag.
module dm_wait_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: memory end of the CPU load/store port.
// One outstanding request, programmable BUSY wait, response held until taken.
// Optional build macro DM_TRACE_EN: prints committed stores and out-of-range accesses.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = DM_DEFAULT_DEPTH,
    parameter int unsigned WAIT_CYCLES = DM_DEFAULT_WAIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [DM_LANES-1:0]  req_be,
    input  logic [DM_DATA_W-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DM_DATA_W-1:0] resp_rdata,
    output logic                 resp_err
);

    localparam int unsigned          IDX_W      = $clog2(DEPTH);
    localparam logic [31:0]          ADDR_LIMIT = DEPTH * 32'd4;
    localparam logic [DM_CNT_W-1:0]  WAIT_LOAD  =
        (WAIT_CYCLES == 0) ? '0 : DM_CNT_W'(WAIT_CYCLES - 1);

    dm_state_t state;
    dm_state_t state_next;

    logic                 lat_we;
    logic [31:0]          lat_addr;
    logic [DM_LANES-1:0]  lat_be;
    logic [DM_DATA_W-1:0] lat_wdata;

    logic [DM_DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic do_access;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    logic                 acc_we;
    logic [31:0]          acc_addr;
    logic [DM_LANES-1:0]  acc_be;
    logic [DM_DATA_W-1:0] acc_wdata;
    logic                 acc_in_range;
    logic [IDX_W-1:0]     acc_idx;

    dm_wait_counter #(.WIDTH(DM_CNT_W)) u_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (WAIT_LOAD),
        .zero       (cnt_zero)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake outputs and access strobe.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        do_access  = 1'b0;
        case (state)
            DM_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        do_access  = 1'b1;
                        state_next = DM_RESP;
                    end else begin
                        cnt_load   = 1'b1;
                        state_next = DM_BUSY;
                    end
                end
            end
            DM_BUSY: begin
                if (cnt_zero) begin
                    do_access  = 1'b1;
                    state_next = DM_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DM_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = DM_IDLE;
                end
            end
            default: state_next = DM_IDLE;
        endcase
    end

    // With no wait the access happens at the accept edge, so it must use the live request.
    always_comb begin
        acc_we       = (state == DM_IDLE) ? req_we    : lat_we;
        acc_addr     = (state == DM_IDLE) ? req_addr  : lat_addr;
        acc_be       = (state == DM_IDLE) ? req_be    : lat_be;
        acc_wdata    = (state == DM_IDLE) ? req_wdata : lat_wdata;
        acc_in_range = (acc_addr < ADDR_LIMIT);
        acc_idx      = acc_addr[IDX_W+1:2];
    end

    // Capture the request fields at the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
        end
    end

    // Word storage: cleared on reset, byte-lane store at the RESP-entry edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_access && acc_we && acc_in_range) begin
            mem[acc_idx] <= dm_merge(mem[acc_idx], acc_wdata, acc_be);
        end
    end

    // Response data and error flag, held stable through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (do_access) begin
            resp_err   <= !acc_in_range;
            resp_rdata <= (!acc_we && acc_in_range) ? mem[acc_idx] : '0;
        end
    end

`ifdef DM_TRACE_EN
    // Simulation trace of committed stores and out-of-range accesses.
    always_ff @(posedge clk) begin
        if (!reset && do_access) begin
            if (!acc_in_range) begin
                $display("DM ERR %h", acc_addr);
            end else if (acc_we) begin
                $display("@%h: *%h <= %h", $time, acc_addr & ~32'd3,
                         dm_merge(mem[acc_idx], acc_wdata, acc_be));
            end
        end
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAIT  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    logic        m_out;
    logic        m_resp;
    logic        m_err;
    logic [31:0] m_rdata;
    int unsigned m_left;
    logic        l_we;
    logic [31:0] l_addr;
    logic [3:0]  l_be;
    logic [31:0] l_wd;
    logic [31:0] mmem [DEPTH];

    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;
    logic        s_oor;
    logic [31:0] s_idx;
    logic        access_now;

    assign s_we   = m_out ? l_we   : req_we;
    assign s_addr = m_out ? l_addr : req_addr;
    assign s_be   = m_out ? l_be   : req_be;
    assign s_wd   = m_out ? l_wd   : req_wdata;
    assign s_oor  = (s_addr >= DEPTH * 4);
    assign s_idx  = s_addr >> 2;
    assign access_now = m_out ? (m_left == 1) : (!m_resp && req_valid && (WAIT == 0));

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (wd & mask);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out   <= 1'b0;
            m_resp  <= 1'b0;
            m_left  <= 0;
            m_err   <= 1'b0;
            m_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) mmem[i] <= '0;
        end else begin
            if (access_now) begin
                m_resp  <= 1'b1;
                m_err   <= s_oor;
                m_rdata <= (s_oor || s_we) ? 32'h0 : mmem[s_idx];
                if (!s_oor && s_we) mmem[s_idx] <= lane_merge(mmem[s_idx], s_wd, s_be);
            end
            if (m_resp && resp_ready) m_resp <= 1'b0;
            if (m_out) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_out <= 1'b0;
            end else if (!m_resp && req_valid) begin
                l_we   <= req_we;
                l_addr <= req_addr;
                l_be   <= req_be;
                l_wd   <= req_wdata;
                if (WAIT != 0) begin
                    m_out  <= 1'b1;
                    m_left <= WAIT;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("req_ready", 32'(req_ready), 32'(!m_out && !m_resp));
            chk("resp_valid", 32'(resp_valid), 32'(m_resp));
            if (m_resp) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", 32'(resp_err), 32'(m_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic scramble();
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_be     = 4'($urandom_range(0, 15));
        req_wdata  = $urandom;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int unsigned hold,
                       output logic [31:0] rd, output logic er, output int unsigned lat);
        int unsigned guard;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
        resp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            timeout("accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        guard = 0;
        while (!resp_valid && guard < 64) begin
            scramble();
            resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
            guard++;
        end
        resp_ready = 1'b0;
        if (guard >= 64) begin
            timeout("response");
            req_valid = 1'b0;
            return;
        end
        rd = resp_rdata;
        er = resp_err;
        repeat (hold) begin
            @(negedge clk);
            scramble();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int unsigned lat;
        logic [31:0] a;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);

        txn(1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
        chk("t1_rdata", rd, 32'h0);
        chk("t1_err", 32'(er), 32'd0);
        chk("t1_latency", lat, 32'd2);

        txn(1'b1, 32'h8, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
        chk("t2_store_rdata", rd, 32'h0);
        txn(1'b0, 32'h8, 4'h0, 32'h0, 1, rd, er, lat);
        chk("t2_load", rd, 32'hDEADBEEF);

        txn(1'b1, 32'h9, 4'b0010, 32'h0000AA00, 0, rd, er, lat);
        txn(1'b0, 32'h8, 4'h0, 32'h0, 0, rd, er, lat);
        chk("t3_lane_merge", rd, 32'hDEADAAEF);

        txn(1'b1, 32'h8, 4'h0, 32'hFFFFFFFF, 0, rd, er, lat);
        txn(1'b0, 32'hA, 4'h0, 32'h0, 0, rd, er, lat);
        chk("be0_noop", rd, 32'hDEADAAEF);

        txn(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 0, rd, er, lat);
        chk("oor_store_err", 32'(er), 32'd1);
        txn(1'b0, 32'h1000, 4'h0, 32'h0, 0, rd, er, lat);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_rdata", rd, 32'h0);
        txn(1'b0, 32'h0, 4'h0, 32'h0, 0, rd, er, lat);
        chk("t4_addr0_rdata", rd, 32'h0);
        chk("t4_addr0_err", 32'(er), 32'd0);

        txn(1'b1, 32'hFFF, 4'b1000, 32'h77000000, 0, rd, er, lat);
        chk("last_word_store_err", 32'(er), 32'd0);
        txn(1'b0, 32'hFFC, 4'h0, 32'h0, 0, rd, er, lat);
        chk("last_word_load", rd, 32'h77000000);

        txn(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 0, rd, er, lat);
        txn(1'b0, 32'h20, 4'h0, 32'h0, 5, rd, er, lat);
        chk("t5_rdata", rd, 32'hCAFEF00D);
        chk("t5_ready_after", 32'(req_ready), 32'd1);

        // Reset while the store is in BUSY.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_be = 4'hF; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk("t6_resp_valid_in_reset", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        txn(1'b0, 32'h4, 4'h0, 32'h0, 0, rd, er, lat);
        chk("t6_load_after_reset", rd, 32'h0);
        chk("t6_err", 32'(er), 32'd0);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h1000 + $urandom_range(0, 15);
                1:       a = $urandom | 32'h8000_0000;
                2:       a = 32'hFFC + $urandom_range(0, 3);
                default: a = $urandom_range(0, 127);
            endcase
            txn(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 3), rd, er, lat);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule
